// File: rtl/div11_seq_r2_if.sv
// Valid/ready handshake bundle for the sequential constant divider.
// The producer/consumer side uses master; the divider uses slave.
interface div11_seq_r2_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [3:0]       out_remainder;

  modport master (
    output in_valid,
    output in_dividend,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_quotient,
    input  out_remainder
  );

  modport slave (
    input  in_valid,
    input  in_dividend,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_quotient,
    output out_remainder
  );
endinterface

// File: rtl/div11_seq_r2.sv
// Radix-4 iterative divider by a small constant: two dividend bits per cycle,
// MSB first, with a registered valid/ready handshake on both sides.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a dividend
//   BUSY  | one quotient digit per cycle, counter runs WIDTH/2 down to 0
//   DONE  | result presented with out_valid until out_ready
module div11_seq_r2 #(
  parameter int WIDTH   = 32,
  parameter int DIVISOR = 11
) (
  input  logic         clk,
  input  logic         rst,
  div11_seq_r2_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int             HALF     = WIDTH / 2;
  localparam int             CW       = $clog2(HALF) + 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(HALF);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [5:0]     DIV6     = 6'(DIVISOR);

  state_t           state;
  logic [3:0]       r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] quo;

  logic [5:0]       t;
  logic [5:0]       s1;
  logic [5:0]       s2;
  logic             b0;
  logic             b1;
  logic             b2;
  logic [1:0]       q_dig;
  logic [3:0]       r_next;
  logic [WIDTH-1:0] quo_next;

  // t < 4*DIVISOR <= 60, so three conditional subtractions always leave t mod DIVISOR.
  always_comb begin
    t        = {r, dvd[WIDTH-1 -: 2]};
    b0       = (t >= DIV6);
    s1       = b0 ? (t - DIV6) : t;
    b1       = (s1 >= DIV6);
    s2       = b1 ? (s1 - DIV6) : s1;
    b2       = (s2 >= DIV6);
    r_next   = b2 ? 4'(s2 - DIV6) : s2[3:0];
    q_dig    = {b1, (b0 & ~b1) | b2};
    quo_next = (quo << 2) | WIDTH'(q_dig);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      bus.in_ready      <= 1'b1;
      bus.out_valid     <= 1'b0;
      bus.out_quotient  <= '0;
      bus.out_remainder <= '0;
      r                 <= '0;
      cnt               <= '0;
      dvd               <= '0;
      quo               <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd          <= bus.in_dividend;
            quo          <= '0;
            r            <= '0;
            cnt          <= CNT_LOAD;
            bus.in_ready <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          dvd <= dvd << 2;
          quo <= quo_next;
          r   <= r_next;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            bus.out_quotient  <= quo_next;
            bus.out_remainder <= r_next;
            bus.out_valid     <= 1'b1;
            state             <= DONE;
          end
        end
        DONE: begin
          // in_ready rises only after the handshake edge, so no same-cycle accept.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

  a_rem_bound: assert property (@(posedge clk) disable iff (rst) r < 4'(DIVISOR));
  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(bus.in_ready && bus.out_valid));

endmodule

// File: doc/div11_seq_r2.md
Name: div11_seq_r2

Overview:
- Sequential radix-4 constant divider. Divides an unsigned WIDTH-bit dividend by DIVISOR (default 11), consuming 2 dividend bits per cycle, MSB first.
- Each step is the same remainder/quotient-digit recurrence that the combinational 6-in/4-out quotient/remainder slices implement: 4-bit remainder plus 2 dividend bits in, next remainder and 2-bit quotient digit out.
- Sits directly upstream of the result consumer. Uses a valid/ready handshake on both input and output, so the combinational slices can be replaced by one registered iterative stage.

Parameters:
- WIDTH, 32, dividend/quotient width; must be even and at least 2.
- DIVISOR, 11, constant divisor; legal range 3..15, so the remainder fits in 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  dividend offered
- in_ready  output  1  block can accept a dividend
- in_dividend  input  WIDTH  unsigned dividend
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- out_quotient  output  WIDTH  floor(dividend / DIVISOR)
- out_remainder  output  4  dividend mod DIVISOR

Behaviour:
- States: IDLE, BUSY, DONE. Internal state: digit counter of width clog2(WIDTH/2)+1, 4-bit remainder register r, WIDTH-bit dividend shift register, WIDTH-bit quotient shift register.
- Reset (asynchronous, immediate on rst high):
  - state=IDLE, in_ready=1, out_valid=0.
  - out_quotient=0, out_remainder=0, r=0, counter=0.
  - Applies in any state. Reset during BUSY or DONE discards the operation; no result is ever presented for it.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: capture in_dividend, set r=0, counter=WIDTH/2, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge: d = top 2 bits of the dividend shift register; t = 4*r + d (6 bits, range 0..4*DIVISOR-1).
  - q = number of DIVISOR multiples not exceeding t (0..3), computed by up to three conditional subtractions. Next r = t - q*DIVISOR.
  - Shift the dividend left by 2. Shift q into the quotient LSBs. Decrement the counter.
  - After the edge where the counter reaches 0: go to DONE, and register out_quotient and out_remainder from the final values.
- DONE:
  - out_valid=1, in_ready=0. Outputs hold stable while out_valid=1 && !out_ready.
  - On out_ready at an edge: out_valid=0, go to IDLE. Outputs keep their last values until the next completion.
- Latency: accept edge T, then out_valid high after edge T+WIDTH/2 (T+16 at default). Minimum initiation interval is WIDTH/2+2 cycles.
- Invariants:
  - r < DIVISOR after every step.
  - Every quotient digit is in 0..3.
  - out_quotient*DIVISOR + out_remainder == dividend.
- in_dividend is ignored except at the accept edge. in_valid outside IDLE has no effect; the upstream holds it.
- A new dividend is never accepted in the same cycle as the result handshake; it is accepted no earlier than the following edge.
- Boundary cases:
  - dividend=0 gives q=0, r=0.
  - Dividend all ones must not overflow t (6-bit width is sufficient).

Test Plan:
1. Reset, then dividend 0x00000000 -> out_valid exactly 16 cycles after accept; quotient 0x00000000, remainder 0.
2. Dividend 0xFFFFFFFF -> quotient 0x1745D174, remainder 3.
3. Dividends 10, 11, 1000 back-to-back with out_ready=1 -> (0,10), (1,0), (90,10); in_ready low throughout BUSY/DONE; no accept in the result-handshake cycle.
4. Dividend 1000 with out_ready held 0 for 5 cycles after out_valid -> outputs stay 90/10 and out_valid stays 1; a single handshake occurs when out_ready rises; in_valid pulses during the stall are ignored.
5. Assert rst asynchronously (mid-cycle) at step 7 of a BUSY operation -> out_valid=0, in_ready=1, outputs=0 immediately. The next dividend 22 yields quotient 2, remainder 0, with no trace of the aborted operation.
6. Random sweep of 10^5 dividends, including 2^k-1 and multiples of 11 ±1, with random out_ready backpressure -> every result matches the reference model, the q*11+r identity holds, and the handshake count in equals the handshake count out.
